opb_register_bank_simulink2ppc: RTL and testbench
=================================================

OPB_REGISTER_BANK_SIMULINK2PPC -- requirements
Module: opb_register_bank_simulink2ppc

Interface
REQ-001 SHALL have parameters: C_BASEADDR, default 32'h01100000, base address; C_HIGHADDR, default 32'h011000FF, high address; C_NUM_CH, default 4 (1..16), channel count; C_DATA_WIDTH, default 32 (1..32), channel width; C_OPB_AWIDTH, default 32; C_OPB_DWIDTH, default 32; C_FAMILY, default "virtex6".
REQ-002 SHALL have port OPB_Clk, input, 1: sole clock.
REQ-003 SHALL have port OPB_Rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have OPB slave inputs OPB_ABus [0:31], OPB_BE [0:3], OPB_DBus [0:31], OPB_RNW, OPB_select and OPB_seqAddr (OPB semantics, bit 0 = MSB).
REQ-005 SHALL have OPB slave outputs Sl_DBus [0:31], Sl_xferAck, Sl_errAck, Sl_retry and Sl_toutSup.
REQ-006 SHALL have port user_data_in, input, C_NUM_CH*C_DATA_WIDTH: channel i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
REQ-007 SHALL have port user_valid, input, C_NUM_CH: per-channel update strobe.
REQ-008 SHALL have port user_snap, input, 1: fabric snapshot request.
REQ-009 SHALL have port snap_done, output, 1: one-cycle pulse when a snapshot is captured.

Function
REQ-010 SHALL use this map (offsets; values LSB-0; OPB_BE[3] = bits 7:0): 0x00 CTRL, 0x04 STATUS, 0x08+4i DATA[i], 0x80+4i COUNT[i].
REQ-011 SHALL decode a transfer when OPB_select is high and OPB_ABus is within [C_BASEADDR, C_HIGHADDR].
REQ-012 SHALL run the bus FSM IDLE->ACK->WAIT->IDLE: decode->ACK; ACK drives Sl_xferAck high for exactly 1 cycle (latency 1 cycle after select); WAIT holds until OPB_select falls; OPB_seqAddr ignored.
REQ-013 SHALL drive Sl_DBus with read data only in the ACK cycle and with zero at all other times.
REQ-014 SHALL tie Sl_errAck, Sl_retry and Sl_toutSup to 0.
REQ-015 SHALL treat unmapped in-range offsets as reads returning 0 and writes ignored, still acked.
REQ-016 SHALL apply writes in the ACK cycle, per byte lane gated by OPB_BE.
REQ-017 SHALL implement CTRL bit0 SNAP_MODE (R/W) and bit1 SNAP_TRIG (write 1 = one-cycle trigger, reads 0).
REQ-018 SHALL, when user_valid[i] is high, load the live register of channel i with its user_data_in slice zero-extended to 32 bits and set STATUS[i].
REQ-019 SHALL clear STATUS bit i on a write of 1 to it (W1C); on simultaneous user_valid[i] and clear, set SHALL win.
REQ-020 SHALL, on SNAP_TRIG or user_snap, copy all live registers into the shadow registers in one cycle and pulse snap_done on the next cycle; simultaneous triggers SHALL give a single capture.
REQ-021 SHALL make a snapshot include a user_valid update arriving in the same cycle (new data).
REQ-022 SHALL make DATA[i] reads return the shadow register when SNAP_MODE=1 and the live register otherwise.

Reset
REQ-023 SHALL, on OPB_Rst, clear FSM to IDLE; Sl_xferAck, Sl_DBus, snap_done, CTRL, STATUS, live, shadow and COUNT to 0.
REQ-024 SHALL abort a transfer in progress on reset mid-transfer without an ack.

Configuration
REQ-025 SHALL, with OPB_REGBANK_UPDCNT_EN defined, provide 32-bit COUNT[i]: incremented on each user_valid[i], saturating at 0xFFFFFFFF, cleared by any write; without the macro, COUNT offsets SHALL read 0 and no counter logic SHALL exist.

Structure
REQ-026 SHALL place the register offsets, CTRL bit indices and the FSM state enumeration in a shared package opb_regbank_pkg.
REQ-027 SHALL implement the bus FSM and decode in one sub-module, opb_slave_if, with channel storage in the top.

Verification
REQ-028 SHALL cover: read 0x00 after reset -> Sl_xferAck 1 cycle after select, data 0x00000000.
REQ-029 SHALL cover: user_valid[2] with ch2=0xDEADBEEF; read 0x10 -> 0xDEADBEEF and STATUS=0x4; write STATUS 0x4 -> reads 0.
REQ-030 SHALL cover: ch0=0x11; write CTRL=0x3; ch0=0x22; read 0x08 -> 0x11; snap_done pulsed once; write CTRL=0x0; read 0x08 -> 0x22.
REQ-031 SHALL cover: user_valid[1] and W1C of bit1 in the same cycle -> STATUS[1]=1.
REQ-032 SHALL cover: with OPB_REGBANK_UPDCNT_EN, 5 pulses of user_valid[3] -> 0x8C reads 5; without it -> 0.
REQ-033 SHALL cover: OPB_Rst asserted during ACK -> no ack, and all registers read 0 afterwards.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// Shared register map, CTRL bit positions, bus FSM states and a byte-lane helper
// for the OPB register bank.
package opb_regbank_pkg;

    localparam logic [31:0] OFF_CTRL       = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS     = 32'h0000_0004;
    localparam logic [31:0] OFF_DATA_BASE  = 32'h0000_0008;
    localparam logic [31:0] OFF_COUNT_BASE = 32'h0000_0080;

    localparam int CTRL_SNAP_MODE_BIT = 0;
    localparam int CTRL_SNAP_TRIG_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } bus_state_e;

    // be[0] enables bits 7:0, be[3] enables bits 31:24 (LSB-0 view of OPB_BE).
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int lane = 0; lane < 4; lane++) begin
            mask[lane*8 +: 8] = {8{be[lane]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/opb_slave_if.sv
// OPB slave address decode and single-beat transfer FSM (IDLE -> ACK -> WAIT);
// latches the transfer at decode and presents a one-cycle write strobe in ACK.
module opb_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0110_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0110_00FF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_abus,
    input  logic [31:0] i_dbus,
    input  logic [3:0]  i_be,
    input  logic        i_rnw,
    input  logic        i_select,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rd_offset,
    output logic        o_wr_en,
    output logic [31:0] o_wr_offset,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_be,
    output logic        o_xfer_ack,
    output logic [31:0] o_dbus
);

    bus_state_e  r_state;
    bus_state_e  w_state_nxt;
    logic        w_hit;
    logic        w_start;
    logic        r_ack;
    logic [31:0] r_dbus;
    logic [31:0] r_offset;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_rnw;

    assign w_hit       = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
    assign w_start     = (r_state == ST_IDLE) && w_hit;
    assign o_rd_offset = i_abus - C_BASEADDR;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; WAIT holds until the master releases select.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_select) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered ack/read data and the transfer latched at decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack    <= 1'b0;
            r_dbus   <= 32'h0000_0000;
            r_offset <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_be     <= 4'h0;
            r_rnw    <= 1'b1;
        end else begin
            r_ack  <= w_start;
            r_dbus <= (w_start && i_rnw) ? i_rdata : 32'h0000_0000;
            if (w_start) begin
                r_offset <= o_rd_offset;
                r_wdata  <= i_dbus;
                r_be     <= i_be;
                r_rnw    <= i_rnw;
            end
        end
    end

    assign o_wr_en     = (r_state == ST_ACK) && !r_rnw;
    assign o_wr_offset = r_offset;
    assign o_wr_data   = r_wdata;
    assign o_wr_be     = r_be;

    // A reset arriving during ACK must suppress the ack and data in that same cycle.
    assign o_xfer_ack = r_ack && !i_rst;
    assign o_dbus     = r_dbus & {32{!i_rst}};

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB register bank: per-channel live/shadow capture with snapshot, W1C status.
// Optional per-channel update counters are built when OPB_REGBANK_UPDCNT_EN is defined.
module opb_register_bank_simulink2ppc
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0110_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0110_00FF,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                               OPB_Clk,
    input  logic                               OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]            OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]          OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]            OPB_DBus,
    input  logic                               OPB_RNW,
    input  logic                               OPB_select,
    input  logic                               OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]            Sl_DBus,
    output logic                               Sl_xferAck,
    output logic                               Sl_errAck,
    output logic                               Sl_retry,
    output logic                               Sl_toutSup,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]   user_data_in,
    input  logic [C_NUM_CH-1:0]                user_valid,
    input  logic                               user_snap,
    output logic                               snap_done
);

    if (C_NUM_CH < 1 || C_NUM_CH > 16 || C_DATA_WIDTH < 1 || C_DATA_WIDTH > 32 ||
        C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 || C_HIGHADDR < C_BASEADDR ||
        C_FAMILY == "") begin : g_bad_cfg
        $error("opb_register_bank_simulink2ppc: unsupported parameter set");
    end

    logic [31:0]         w_abus;
    logic [31:0]         w_dbus_in;
    logic [3:0]          w_be_in;
    logic [31:0]         w_rd_offset;
    logic [31:0]         w_rdata;
    logic                w_wr_en;
    logic [31:0]         w_wr_offset;
    logic [31:0]         w_wr_data;
    logic [3:0]          w_wr_be;
    logic [31:0]         w_wr_mask;
    logic [31:0]         w_sl_dbus;
    logic                w_wr_ctrl;
    logic                w_wr_status;
    logic                w_snap_trig;
    logic                w_snap;
    logic [C_NUM_CH-1:0] w_status_clr;
    logic [31:0]         w_new_data [C_NUM_CH];
    logic                w_unused_ok;

    logic                r_snap_mode;
    logic [C_NUM_CH-1:0] r_status;
    logic                r_snap_done;
    logic [31:0]         r_live   [C_NUM_CH];
    logic [31:0]         r_shadow [C_NUM_CH];

    // OPB numbers bit 0 as MSB; positional assignment yields the LSB-0 value.
    assign w_abus    = OPB_ABus;
    assign w_dbus_in = OPB_DBus;
    assign w_be_in   = OPB_BE;

    opb_slave_if #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_slave_if (
        .i_clk       (OPB_Clk),
        .i_rst       (OPB_Rst),
        .i_abus      (w_abus),
        .i_dbus      (w_dbus_in),
        .i_be        (w_be_in),
        .i_rnw       (OPB_RNW),
        .i_select    (OPB_select),
        .i_rdata     (w_rdata),
        .o_rd_offset (w_rd_offset),
        .o_wr_en     (w_wr_en),
        .o_wr_offset (w_wr_offset),
        .o_wr_data   (w_wr_data),
        .o_wr_be     (w_wr_be),
        .o_xfer_ack  (Sl_xferAck),
        .o_dbus      (w_sl_dbus)
    );

    assign Sl_DBus    = w_sl_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_done  = r_snap_done;

    assign w_wr_mask    = be_to_mask(w_wr_be);
    assign w_wr_ctrl    = w_wr_en && (w_wr_offset == OFF_CTRL);
    assign w_wr_status  = w_wr_en && (w_wr_offset == OFF_STATUS);
    assign w_snap_trig  = w_wr_ctrl && w_wr_mask[CTRL_SNAP_TRIG_BIT] && w_wr_data[CTRL_SNAP_TRIG_BIT];
    assign w_snap       = w_snap_trig || user_snap;
    assign w_status_clr = w_wr_status ? (w_wr_data[C_NUM_CH-1:0] & w_wr_mask[C_NUM_CH-1:0])
                                      : {C_NUM_CH{1'b0}};

    // Zero-extend each channel slice to a full register word.
    always_comb begin
        for (int ch = 0; ch < C_NUM_CH; ch++) begin
            w_new_data[ch] = 32'h0000_0000;
            w_new_data[ch][C_DATA_WIDTH-1:0] = user_data_in[ch*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    end

    // CTRL.SNAP_MODE; SNAP_TRIG is a write-only strobe and has no storage.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_snap_mode <= 1'b0;
        end else if (w_wr_ctrl && w_wr_mask[CTRL_SNAP_MODE_BIT]) begin
            r_snap_mode <= w_wr_data[CTRL_SNAP_MODE_BIT];
        end
    end

    // Live capture and shadow snapshot; a same-cycle update lands in the snapshot.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                r_live[ch]   <= 32'h0000_0000;
                r_shadow[ch] <= 32'h0000_0000;
            end
        end else begin
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                if (user_valid[ch]) begin
                    r_live[ch] <= w_new_data[ch];
                end
                if (w_snap) begin
                    r_shadow[ch] <= user_valid[ch] ? w_new_data[ch] : r_live[ch];
                end
            end
        end
    end

    // W1C status with set priority, and the snapshot completion pulse.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_status    <= {C_NUM_CH{1'b0}};
            r_snap_done <= 1'b0;
        end else begin
            r_status    <= user_valid | (r_status & ~w_status_clr);
            r_snap_done <= w_snap;
        end
    end

`ifdef OPB_REGBANK_UPDCNT_EN
    logic [31:0] r_count [C_NUM_CH];

    // Saturating update counters; any write to a counter clears it.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                r_count[ch] <= 32'h0000_0000;
            end
        end else begin
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                if (w_wr_en && (w_wr_offset == OFF_COUNT_BASE + 32'(4 * ch))) begin
                    r_count[ch] <= 32'h0000_0000;
                end else if (user_valid[ch] && (r_count[ch] != 32'hFFFF_FFFF)) begin
                    r_count[ch] <= r_count[ch] + 32'd1;
                end
            end
        end
    end
`endif

    // Read mux on the live bus address; unmapped offsets return zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_rd_offset == OFF_CTRL) begin
            w_rdata[CTRL_SNAP_MODE_BIT] = r_snap_mode;
        end else if (w_rd_offset == OFF_STATUS) begin
            w_rdata[C_NUM_CH-1:0] = r_status;
        end else begin
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                w_rdata = (w_rd_offset == OFF_DATA_BASE + 32'(4 * ch))
                        ? (r_snap_mode ? r_shadow[ch] : r_live[ch]) : w_rdata;
            end
`ifdef OPB_REGBANK_UPDCNT_EN
            for (int ch = 0; ch < C_NUM_CH; ch++) begin
                w_rdata = (w_rd_offset == OFF_COUNT_BASE + 32'(4 * ch)) ? r_count[ch] : w_rdata;
            end
`endif
        end
    end

    assign w_unused_ok = ^{OPB_seqAddr, w_wr_data, w_wr_mask};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Self-checking bench: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model of the register bank.
`timescale 1ns/1ps
module tb_opb_register_bank_simulink2ppc;

    localparam int          NCH  = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0110_0000;
    localparam logic [31:0] HIGH = 32'h0110_00FF;

    logic            OPB_Clk = 1'b0;
    logic            OPB_Rst = 1'b1;
    logic [0:31]     OPB_ABus = 32'h0;
    logic [0:3]      OPB_BE = 4'h0;
    logic [0:31]     OPB_DBus = 32'h0;
    logic            OPB_RNW = 1'b1;
    logic            OPB_select = 1'b0;
    logic            OPB_seqAddr = 1'b0;
    logic [0:31]     Sl_DBus;
    logic            Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [NCH*DW-1:0] user_data_in = '0;
    logic [NCH-1:0]  user_valid = '0;
    logic            user_snap = 1'b0;
    logic            snap_done;

    int checks = 0;
    int errors = 0;
    int snap_cnt = 0;
    int ack_cnt = 0;

    opb_register_bank_simulink2ppc dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
        .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_in(user_data_in), .user_valid(user_valid), .user_snap(user_snap),
        .snap_done(snap_done)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]    m_live [NCH];
    logic [31:0]    m_shadow [NCH];
    logic [31:0]    m_count [NCH];
    logic [NCH-1:0] m_status;
    logic           m_mode;
    bit             m_busy;
    bit             m_ok = 1'b0;
    logic           e_ack, e_snap;
    logic [31:0]    e_dbus;
    logic [31:0]    l_off, l_data;
    logic [0:3]     l_be;
    logic           l_rnw;

    // OPB_BE[3] covers value bits 7:0, OPB_BE[0] bits 31:24.
    function automatic bit lane_on(input logic [0:3] be, input int b);
        return be[3 - b/8];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] off);
        if (off == 32'h0) return {31'b0, m_mode};
        if (off == 32'h4) return 32'(m_status);
        for (int i = 0; i < NCH; i++)
            if (off == 32'(8 + 4*i)) return m_mode ? m_shadow[i] : m_live[i];
`ifdef OPB_REGBANK_UPDCNT_EN
        for (int i = 0; i < NCH; i++)
            if (off == 32'(128 + 4*i)) return m_count[i];
`endif
        return 32'h0;
    endfunction

    always @(posedge OPB_Clk) begin
        logic [31:0]    addr, rd;
        logic [NCH-1:0] clr;
        bit             trig, hit;
        bit             cclr [NCH];
        if (OPB_Rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_live[i] = '0; m_shadow[i] = '0; m_count[i] = '0;
            end
            m_status = '0; m_mode = 1'b0; m_busy = 1'b0;
            e_ack = 1'b0; e_snap = 1'b0; e_dbus = '0; l_rnw = 1'b1;
            m_ok = 1'b1;
        end else if (m_ok) begin
            addr = OPB_ABus;
            hit  = OPB_select && addr >= BASE && addr <= HIGH;
            rd   = m_read(addr - BASE);
            trig = 1'b0; clr = '0;
            for (int i = 0; i < NCH; i++) cclr[i] = 1'b0;
            if (e_ack && !l_rnw) begin
                if (l_off == 32'h0 && lane_on(l_be, 0)) begin
                    m_mode = l_data[0]; trig = l_data[1];
                end
                if (l_off == 32'h4)
                    for (int b = 0; b < NCH; b++) clr[b] = lane_on(l_be, b) && l_data[b];
                for (int i = 0; i < NCH; i++) cclr[i] = (l_off == 32'(128 + 4*i));
            end
            for (int i = 0; i < NCH; i++) begin
                if (user_valid[i]) m_live[i] = user_data_in[i*DW +: DW];
                if (cclr[i]) m_count[i] = '0;
                else if (user_valid[i] && m_count[i] != 32'hFFFF_FFFF) m_count[i] += 1;
            end
            if (trig || user_snap)
                for (int i = 0; i < NCH; i++) m_shadow[i] = m_live[i];
            m_status = (m_status & ~clr) | user_valid;
            e_snap = trig || user_snap;
            if (!m_busy && hit) begin
                e_ack = 1'b1; e_dbus = OPB_RNW ? rd : 32'h0; m_busy = 1'b1;
                l_off = addr - BASE; l_data = OPB_DBus; l_be = OPB_BE; l_rnw = OPB_RNW;
            end else begin
                if (m_busy && !e_ack && !OPB_select) m_busy = 1'b0;
                e_ack = 1'b0; e_dbus = 32'h0;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge OPB_Clk) begin
        if (m_ok) begin
            check("xferAck", {31'b0, Sl_xferAck}, {31'b0, e_ack && !OPB_Rst});
            check("Sl_DBus", Sl_DBus, OPB_Rst ? 32'h0 : e_dbus);
            check("snap_done", {31'b0, snap_done}, {31'b0, e_snap});
            check("tied_outputs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        end
        if (snap_done === 1'b1) snap_cnt++;
        if (Sl_xferAck === 1'b1) ack_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                            input logic [0:3] be, input logic [NCH-1:0] vmask,
                            output logic [31:0] rdata, output int lat);
        bit got;
        got = 1'b0; lat = 0; rdata = '0;
        OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_BE = be; OPB_select = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge OPB_Clk); #1;
            if (k == 0) user_valid = vmask;
            lat++;
            @(negedge OPB_Clk);
            if (Sl_xferAck === 1'b1) begin got = 1'b1; rdata = Sl_DBus; end
        end
        @(posedge OPB_Clk); #1;
        user_valid = '0; OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0; OPB_BE = '0;
        @(posedge OPB_Clk); #1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_timeout: no ack for addr %h, required ack within 8 cycles", addr);
        end
    endtask

    task automatic rd(input logic [31:0] off, input string name, input logic [31:0] exp);
        logic [31:0] d; int lat;
        bus_xfer(BASE + off, 1'b1, 32'h0, 4'h0, '0, d, lat);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [0:3] be);
        logic [31:0] d; int lat;
        bus_xfer(BASE + off, 1'b0, data, be, '0, d, lat);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] val);
        user_data_in[ch*DW +: DW] = val;
        user_valid[ch] = 1'b1;
        @(posedge OPB_Clk); #1;
        user_valid[ch] = 1'b0;
    endtask

    logic [31:0] offs [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
                               32'h18, 32'h80, 32'h8C, 32'hFC};

    initial begin
        logic [31:0] d;
        int lat, s0, a0, hold;
        bit ack_seen;
        repeat (3) @(posedge OPB_Clk);
        #1 OPB_Rst = 1'b0;

        bus_xfer(BASE, 1'b1, 32'h0, 4'h0, '0, d, lat);
        check("ctrl_after_reset", d, 32'h0);
        check("ack_latency", 32'(lat), 32'd1);
        rd(32'h4, "status_after_reset", 32'h0);

        set_ch(2, 32'hDEAD_BEEF);
        rd(32'h10, "data2_live", 32'hDEAD_BEEF);
        rd(32'h4, "status_ch2", 32'h4);
        wr(32'h4, 32'h4, 4'hF);
        rd(32'h4, "status_w1c", 32'h0);

        set_ch(0, 32'h11);
        s0 = snap_cnt;
        wr(32'h0, 32'h3, 4'hF);
        set_ch(0, 32'h22);
        rd(32'h8, "data0_shadow", 32'h11);
        check("snap_done_once", 32'(snap_cnt - s0), 32'd1);
        rd(32'h0, "ctrl_trig_reads0", 32'h1);
        wr(32'h0, 32'h0, 4'hF);
        rd(32'h8, "data0_live", 32'h22);

        bus_xfer(BASE + 32'h4, 1'b0, 32'h2, 4'hF, 4'b0010, d, lat);
        rd(32'h4, "status_set_wins", 32'h3);

        for (int i = 0; i < 5; i++) set_ch(3, 32'(i + 100));
`ifdef OPB_REGBANK_UPDCNT_EN
        rd(32'h8C, "count3", 32'd5);
`else
        rd(32'h8C, "count3", 32'd0);
`endif
        wr(32'h8C, 32'h0, 4'h0);
        rd(32'h8C, "count3_cleared", 32'd0);

        wr(32'h0, 32'h1, 4'b1110);
        rd(32'h0, "ctrl_lane_masked", 32'h0);
        wr(32'h0, 32'h1, 4'b0001);
        rd(32'h0, "ctrl_lane_enabled", 32'h1);
        rd(32'h18, "unmapped_0x18", 32'h0);
        rd(32'hFC, "unmapped_0xFC", 32'h0);

        a0 = ack_cnt;
        OPB_ABus = BASE + 32'h100; OPB_RNW = 1'b1; OPB_select = 1'b1;
        repeat (4) @(posedge OPB_Clk);
        #1 OPB_select = 1'b0;
        OPB_ABus = BASE - 32'h4; OPB_select = 1'b1;
        repeat (4) @(posedge OPB_Clk);
        #1 OPB_select = 1'b0;
        check("out_of_range_no_ack", 32'(ack_cnt - a0), 32'd0);

        OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1 OPB_Rst = 1'b1;
        @(negedge OPB_Clk);
        check("ack_in_reset", {31'b0, Sl_xferAck}, 32'h0);
        @(posedge OPB_Clk); #1 OPB_Rst = 1'b0; OPB_select = 1'b0;
        @(posedge OPB_Clk); #1;
        rd(32'h0, "post_rst_ctrl", 32'h0);
        rd(32'h4, "post_rst_status", 32'h0);
        for (int i = 0; i < NCH; i++) rd(32'(8 + 4*i), "post_rst_live", 32'h0);
        for (int i = 0; i < NCH; i++) rd(32'(128 + 4*i), "post_rst_count", 32'h0);
        wr(32'h0, 32'h1, 4'hF);
        for (int i = 0; i < NCH; i++) rd(32'(8 + 4*i), "post_rst_shadow", 32'h0);
        wr(32'h0, 32'h0, 4'hF);

        hold = 0; ack_seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            user_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            user_valid   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            user_snap    = ($urandom_range(0, 15) == 0);
            if (!OPB_select) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 9) == 0)
                        OPB_ABus = ($urandom_range(0, 1) == 0) ? BASE + 32'h100 : BASE - 32'h4;
                    else
                        OPB_ABus = BASE + offs[$urandom_range(0, 9)];
                    OPB_RNW    = 1'($urandom_range(0, 1));
                    OPB_DBus   = $urandom();
                    OPB_BE     = 4'($urandom_range(0, 15));
                    OPB_select = 1'b1;
                    hold = 0;
                end
            end else if (ack_seen) begin
                OPB_select = 1'b0;
            end else begin
                hold++;
                if (hold > 4) OPB_select = 1'b0;
            end
            @(negedge OPB_Clk);
            ack_seen = (Sl_xferAck === 1'b1);
            @(posedge OPB_Clk); #1;
        end
        OPB_select = 1'b0; user_valid = '0; user_snap = 1'b0;
        repeat (3) @(posedge OPB_Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
